// File: rtl/sift_pkg.sv
// Shared SIFT front-end definitions: image geometry, scheduler states and blur radii.
package sift_pkg;

    localparam int unsigned IMG_COLS = 640;
    localparam int unsigned IMG_ROWS = 480;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        FETCH = 3'd1,
        FWAIT = 3'd2,
        START = 3'd3,
        EWAIT = 3'd4,
        WRITE = 3'd5,
        LDONE = 3'd6
    } state_e;

    // Kernel radius of each cascaded Gaussian layer (3x3, 5x5, 5x5, 7x7).
    localparam logic [1:0] LAYER_RADIUS [0:3] = '{2'd1, 2'd2, 2'd2, 2'd3};

endpackage

// File: rtl/gauss_layer_sched.sv
// Sequences the four Gaussian blur layers over the image: primes the engine line
// window with border-clamped row fetches, triggers one output row at a time, writes it back.
module gauss_layer_sched
    import sift_pkg::*;
#(
    parameter int unsigned ROWS   = IMG_ROWS,
    parameter int unsigned ROW_W  = 9,
    parameter int unsigned RD_LAT = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    output logic             busy,
    output logic [1:0]       layer,
    output logic             rd_en,
    output logic [1:0]       rd_sel,
    output logic [ROW_W-1:0] rd_row,
    output logic             lb_push,
    output logic             eng_start,
    output logic [1:0]       eng_radius,
    input  logic             eng_done,
    output logic             wr_en,
    output logic [ROW_W-1:0] wr_row,
    output logic [ROW_W-1:0] cur_row,
    output logic [3:0]       gaussian_done,
    output logic             all_done
);

    localparam int unsigned LAT_W = (RD_LAT > 1) ? $clog2(RD_LAT) : 1;
    localparam int unsigned SUM_W = ROW_W + 2;
    localparam logic [ROW_W-1:0] LAST_ROW = ROW_W'(ROWS - 1);

    state_e           r_state, w_state_nx;
    logic [1:0]       r_layer, w_layer_nx;
    logic [ROW_W-1:0] r_cur_row, w_cur_row_nx;
    logic [ROW_W-1:0] r_rd_row, w_rd_row_nx;
    logic [ROW_W-1:0] r_wr_row, w_wr_row_nx;
    logic [2:0]       r_prime, w_prime_nx;
    logic [LAT_W-1:0] r_lat, w_lat_nx;
    logic [3:0]       r_gdone, w_gdone_nx;
    logic             w_all_done_nx;

    logic r_rd_en, r_lb_push, r_eng_start, r_wr_en, r_busy, r_all_done;

    logic [1:0]       w_radius;
    logic [2:0]       w_nfetch;
    logic [ROW_W-1:0] w_prime_row;
    logic [SUM_W-1:0] w_sum;
    logic [ROW_W-1:0] w_next_fetch;

    // Priming rows are 0 (R+1 times) then 1..R; steady-state fetch is clamped to the last row.
    always_comb begin
        w_radius     = LAYER_RADIUS[r_layer];
        w_nfetch     = {w_radius, 1'b1};
        w_prime_row  = (r_prime <= {1'b0, w_radius}) ? '0
                                                     : ROW_W'(r_prime - {1'b0, w_radius});
        w_sum        = SUM_W'(r_cur_row) + SUM_W'(1) + SUM_W'(w_radius);
        w_next_fetch = (w_sum >= SUM_W'(ROWS - 1)) ? LAST_ROW : ROW_W'(w_sum);
    end

    always_comb begin
        w_state_nx    = r_state;
        w_layer_nx    = r_layer;
        w_cur_row_nx  = r_cur_row;
        w_rd_row_nx   = r_rd_row;
        w_wr_row_nx   = r_wr_row;
        w_prime_nx    = r_prime;
        w_lat_nx      = r_lat;
        w_gdone_nx    = r_gdone;
        w_all_done_nx = 1'b0;
        case (r_state)
            IDLE: begin
                if (start) begin
                    w_gdone_nx   = '0;
                    w_layer_nx   = '0;
                    w_cur_row_nx = '0;
                    w_prime_nx   = '0;
                    w_rd_row_nx  = '0;
                    w_state_nx   = FETCH;
                end
            end
            FETCH: begin
                if (r_prime < w_nfetch) begin
                    w_prime_nx = r_prime + 3'd1;
                end
                w_lat_nx   = LAT_W'(RD_LAT - 1);
                w_state_nx = FWAIT;
            end
            FWAIT: begin
                if (r_lat != '0) begin
                    w_lat_nx = r_lat - LAT_W'(1);
                end else if (r_prime < w_nfetch) begin
                    w_rd_row_nx = w_prime_row;
                    w_state_nx  = FETCH;
                end else begin
                    w_state_nx = START;
                end
            end
            START: begin
                w_state_nx = EWAIT;
            end
            EWAIT: begin
                if (eng_done) begin
                    w_wr_row_nx = r_cur_row;
                    w_state_nx  = WRITE;
                end
            end
            WRITE: begin
                if (r_cur_row == LAST_ROW) begin
                    w_all_done_nx = (r_layer == 2'd3);
                    w_state_nx    = LDONE;
                end else begin
                    w_cur_row_nx = r_cur_row + ROW_W'(1);
                    w_rd_row_nx  = w_next_fetch;
                    w_state_nx   = FETCH;
                end
            end
            LDONE: begin
                w_gdone_nx[r_layer] = 1'b1;
                if (r_layer != 2'd3) begin
                    w_layer_nx   = r_layer + 2'd1;
                    w_cur_row_nx = '0;
                    w_prime_nx   = '0;
                    w_rd_row_nx  = '0;
                    w_state_nx   = FETCH;
                end else begin
                    w_state_nx = IDLE;
                end
            end
            default: begin
                w_state_nx = IDLE;
            end
        endcase
    end

    // Strobes are registered from the next-state decode so they line up with their state.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= IDLE;
            r_layer     <= '0;
            r_cur_row   <= '0;
            r_rd_row    <= '0;
            r_wr_row    <= '0;
            r_prime     <= '0;
            r_lat       <= '0;
            r_gdone     <= '0;
            r_rd_en     <= 1'b0;
            r_lb_push   <= 1'b0;
            r_eng_start <= 1'b0;
            r_wr_en     <= 1'b0;
            r_busy      <= 1'b0;
            r_all_done  <= 1'b0;
        end else begin
            r_state     <= w_state_nx;
            r_layer     <= w_layer_nx;
            r_cur_row   <= w_cur_row_nx;
            r_rd_row    <= w_rd_row_nx;
            r_wr_row    <= w_wr_row_nx;
            r_prime     <= w_prime_nx;
            r_lat       <= w_lat_nx;
            r_gdone     <= w_gdone_nx;
            r_rd_en     <= (w_state_nx == FETCH);
            r_lb_push   <= (w_state_nx == FWAIT) && (w_lat_nx == '0);
            r_eng_start <= (w_state_nx == START);
            r_wr_en     <= (w_state_nx == WRITE);
            r_busy      <= (w_state_nx != IDLE);
            r_all_done  <= w_all_done_nx;
        end
    end

    assign busy          = r_busy;
    assign layer         = r_layer;
    assign rd_en         = r_rd_en;
    assign rd_sel        = r_layer;
    assign rd_row        = r_rd_row;
    assign lb_push       = r_lb_push;
    assign eng_start     = r_eng_start;
    assign eng_radius    = LAYER_RADIUS[r_layer];
    assign wr_en         = r_wr_en;
    assign wr_row        = r_wr_row;
    assign cur_row       = r_cur_row;
    assign gaussian_done = r_gdone;
    assign all_done      = r_all_done;

endmodule

// File: tb/tb_gauss_layer_sched.sv
// Scoreboard bench for gauss_layer_sched: directed fetch/write tables, protocol monitors,
// spurious-input, mid-run reset and RD_LAT=3 checks.
module tb_gauss_layer_sched;

    localparam int unsigned ROWS  = 8;
    localparam int unsigned ROW_W = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             rst, start, start3, spur;
    logic             busy, rd_en, lb_push, eng_start, eng_done, wr_en, all_done;
    logic [1:0]       layer, rd_sel, eng_radius;
    logic [ROW_W-1:0] rd_row, wr_row, cur_row;
    logic [3:0]       gd;

    logic             busy3, rd_en3, lb_push3, eng_start3, eng_done3, wr_en3, all_done3;
    logic [1:0]       layer3, rd_sel3, eng_radius3;
    logic [ROW_W-1:0] rd_row3, wr_row3, cur_row3;
    logic [3:0]       gd3;

    gauss_layer_sched #(.ROWS(ROWS), .ROW_W(ROW_W), .RD_LAT(1)) dut (
        .clk(clk), .rst(rst), .start(start), .busy(busy), .layer(layer),
        .rd_en(rd_en), .rd_sel(rd_sel), .rd_row(rd_row), .lb_push(lb_push),
        .eng_start(eng_start), .eng_radius(eng_radius), .eng_done(eng_done),
        .wr_en(wr_en), .wr_row(wr_row), .cur_row(cur_row),
        .gaussian_done(gd), .all_done(all_done)
    );

    gauss_layer_sched #(.ROWS(ROWS), .ROW_W(ROW_W), .RD_LAT(3)) dut3 (
        .clk(clk), .rst(rst), .start(start3), .busy(busy3), .layer(layer3),
        .rd_en(rd_en3), .rd_sel(rd_sel3), .rd_row(rd_row3), .lb_push(lb_push3),
        .eng_start(eng_start3), .eng_radius(eng_radius3), .eng_done(eng_done3),
        .wr_en(wr_en3), .wr_row(wr_row3), .cur_row(cur_row3),
        .gaussian_done(gd3), .all_done(all_done3)
    );

    // Engine models: eng_done four cycles after eng_start.
    int eng_cnt, eng_cnt3;
    always @(posedge clk) begin
        if (rst) eng_cnt <= 0;
        else if (eng_start) eng_cnt <= 4;
        else if (eng_cnt > 0) eng_cnt <= eng_cnt - 1;
    end
    always @(posedge clk) begin
        if (rst) eng_cnt3 <= 0;
        else if (eng_start3) eng_cnt3 <= 4;
        else if (eng_cnt3 > 0) eng_cnt3 <= eng_cnt3 - 1;
    end
    assign eng_done  = (eng_cnt == 1) | spur;
    assign eng_done3 = (eng_cnt3 == 1);

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string name, input int act, input int exp);
        n_tests++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic fail_now(input string name, input int act);
        n_tests++;
        n_fail++;
        $display("FAIL %s: got %0d with nothing expected at %0t", name, act, $time);
    endtask

    // Hand-computed fetch rows for ROWS=8 per layer (R = 1, 2, 2, 3).
    int fetch_tbl [48];
    int fetch_off [4];
    int fetch_len [4];
    int rad_tbl   [4];
    int exp_rd [$];
    int exp_wr [$];

    task automatic push_run();
        for (int l = 0; l < 4; l++) begin
            for (int k = 0; k < fetch_len[l]; k++)
                exp_rd.push_back(l * 256 + fetch_tbl[fetch_off[l] + k]);
            for (int r = 0; r < int'(ROWS); r++)
                exp_wr.push_back(l * 256 + r);
        end
    endtask

    // Monitor for the RD_LAT=1 instance.
    logic       prev_rd, pending;
    logic [1:0] prev_layer;
    int         pushes;
    int         n_all_done = 0;
    always @(negedge clk) begin
        if (rst) begin
            prev_rd    <= 1'b0;
            pending    <= 1'b0;
            pushes     <= 0;
            prev_layer <= 2'd0;
        end else begin
            prev_rd    <= rd_en;
            prev_layer <= layer;
            if (lb_push || prev_rd) check("lb_push_after_rd_en", int'(lb_push), int'(prev_rd));
            if (rd_en) begin
                check("rd_in_flight", int'(pending), 0);
                pending <= 1'b1;
                if (exp_rd.size() == 0) fail_now("rd_unexpected", int'(rd_sel) * 256 + int'(rd_row));
                else check("rd_sel_row", int'(rd_sel) * 256 + int'(rd_row), exp_rd.pop_front());
            end else if (lb_push) begin
                pending <= 1'b0;
            end
            if (!busy) pushes <= 0;
            else if (layer != prev_layer) pushes <= lb_push ? 1 : 0;
            else if (lb_push) pushes <= pushes + 1;
            if (eng_start) begin
                check("eng_radius", int'(eng_radius), rad_tbl[layer]);
                if (cur_row == '0) check("prime_pushes", pushes, 2 * rad_tbl[layer] + 1);
            end
            if (wr_en) begin
                if (exp_wr.size() == 0) fail_now("wr_unexpected", int'(layer) * 256 + int'(wr_row));
                else check("wr_layer_row", int'(layer) * 256 + int'(wr_row), exp_wr.pop_front());
            end
            if (all_done) n_all_done <= n_all_done + 1;
        end
    end

    // Monitor for the RD_LAT=3 instance: push latency and layer-0 fetch count.
    logic [2:0] hist3;
    int         cnt3;
    logic       gd3_prev;
    always @(negedge clk) begin
        if (rst) begin
            hist3    <= '0;
            cnt3     <= 0;
            gd3_prev <= 1'b0;
        end else begin
            hist3    <= {hist3[1:0], rd_en3};
            gd3_prev <= gd3[0];
            if (lb_push3 || hist3[2]) check("lb_push_lat3", int'(lb_push3), int'(hist3[2]));
            if (rd_en3 && !gd3[0]) cnt3 <= cnt3 + 1;
            if (gd3[0] && !gd3_prev) check("fetch_cnt3", cnt3, 10);
        end
    end

    task automatic wait_all_done(input string name);
        int g = 0;
        while (all_done !== 1'b1 && g < 3000) begin
            @(negedge clk);
            g++;
        end
        if (g >= 3000) fail_now(name, g);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        int g;
        int ad0;
        fetch_tbl = '{0,0,1,2,3,4,5,6,7,7,
                      0,0,0,1,2,3,4,5,6,7,7,7,
                      0,0,0,1,2,3,4,5,6,7,7,7,
                      0,0,0,0,1,2,3,4,5,6,7,7,7,7};
        fetch_off = '{0, 10, 22, 34};
        fetch_len = '{10, 12, 12, 14};
        rad_tbl   = '{1, 2, 2, 3};
        rst = 1'b1; start = 1'b1; start3 = 1'b0; spur = 1'b0;
        repeat (3) @(negedge clk);
        rst = 1'b0; start = 1'b0;
        @(negedge clk);
        check("rst_busy", int'(busy), 0);
        check("rst_layer", int'(layer), 0);
        check("rst_cur_row", int'(cur_row), 0);
        check("rst_gd", int'(gd), 0);
        check("rst_strobes", int'({rd_en, lb_push, eng_start, wr_en, all_done}), 0);

        // Full run, with spurious eng_done and a redundant start during layer 1.
        push_run();
        ad0 = n_all_done;
        start3 = 1'b1;
        pulse_start();
        start3 = 1'b0;
        check("busy_after_start", int'(busy), 1);
        g = 0;
        while (gd[0] !== 1'b1 && g < 2000) begin @(negedge clk); g++; end
        if (g >= 2000) fail_now("layer0_timeout", g);
        check("gd_after_layer0", int'(gd), 1);
        g = 0;
        while (!(rd_en && layer == 2'd1) && g < 200) begin @(negedge clk); g++; end
        if (g >= 200) fail_now("layer1_fetch_timeout", g);
        spur = 1'b1; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        @(negedge clk);
        spur = 1'b0;
        check("gd_kept", int'(gd), 1);
        check("busy_kept", int'(busy), 1);
        check("layer_kept", int'(layer), 1);
        wait_all_done("all_done_timeout");
        check("layer_at_all_done", int'(layer), 3);
        @(negedge clk);
        check("busy_after_ldone", int'(busy), 0);
        check("gd_all", int'(gd), 15);
        check("layer_no_wrap", int'(layer), 3);
        repeat (5) @(negedge clk);
        check("all_done_pulses", n_all_done - ad0, 1);
        check("rd_queue_empty", exp_rd.size(), 0);
        check("wr_queue_empty", exp_wr.size(), 0);
        check("dut3_layer0_done", int'(gd3[0]), 1);

        // Reset in EWAIT of layer 2, row 5.
        push_run();
        pulse_start();
        g = 0;
        while (!(eng_start && layer == 2'd2 && cur_row == 3'd5) && g < 2000) begin @(negedge clk); g++; end
        if (g >= 2000) fail_now("l2r5_timeout", g);
        @(negedge clk);
        rst = 1'b1;
        exp_rd.delete();
        exp_wr.delete();
        @(negedge clk);
        rst = 1'b0;
        check("rst2_busy", int'(busy), 0);
        check("rst2_gd", int'(gd), 0);
        check("rst2_layer", int'(layer), 0);
        check("rst2_rows", int'({rd_row, wr_row, cur_row}), 0);
        check("rst2_strobes", int'({rd_en, lb_push, eng_start, wr_en, all_done}), 0);
        repeat (10) @(negedge clk);
        check("idle_after_rst", int'(busy), 0);

        // Restart runs from layer 0, row 0.
        push_run();
        ad0 = n_all_done;
        pulse_start();
        wait_all_done("rerun_timeout");
        @(negedge clk);
        check("rerun_gd", int'(gd), 15);
        check("rerun_busy", int'(busy), 0);
        check("rerun_all_done", n_all_done - ad0, 1);
        check("rerun_rd_empty", exp_rd.size(), 0);
        check("rerun_wr_empty", exp_wr.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
